// File: rtl/cmd_sequencer.sv
// cmd_sequencer: decodes 16-bit host commands into heading/move/solve
//   requests, waits for completion from navigation or the solver, then
//   emits one response byte to the transmit wrapper.
// Latency: cmd_rdy sampled -> clr_cmd_rdy/strobe next cycle; completion
//   sampled -> send_resp two cycles later. All outputs registered.
// Backpressure: while busy (not IDLE) cmd_rdy is left pending and
//   clr_cmd_rdy stays low until the block is back in IDLE.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd, cmd_rdy        command word and its held-valid flag
//   clr_cmd_rdy         one-cycle pulse, command consumed
//   strt_hdng/dsrd_hdng heading start pulse and held target heading
//   strt_mv/stp_lft/stp_rght  move start pulse and held stop qualifiers
//   mv_cmplt            heading/move done (from navigation)
//   strt_slv/slv_lft_affn     solve start pulse and held affinity
//   sol_cmplt           solver done
//   cmd_md              1 = command mode, 0 = solver owns navigation
//   send_resp/resp      one-cycle transmit pulse and held response byte
//
// Optional: define CMD_TIMEOUT_EN to add a completion watchdog that
//   answers 8'hE7 if no completion arrives within TIMEOUT_CYC cycles.
module cmd_sequencer #(
  parameter logic [7:0]  ACK = 8'hA5,
  parameter logic [7:0]  NAK = 8'hEE
`ifdef CMD_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        strt_hdng,
  output logic [11:0] dsrd_hdng,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  input  logic        mv_cmplt,
  output logic        strt_slv,
  output logic        slv_lft_affn,
  input  logic        sol_cmplt,
  output logic        cmd_md,
  output logic        send_resp,
  output logic [7:0]  resp
);

  typedef enum logic [2:0] {IDLE, WT_HDNG, WT_MV, WT_SLV, RESP} state_t;

  localparam logic [2:0] OP_HDNG  = 3'b001;
  localparam logic [2:0] OP_MOVE  = 3'b010;
  localparam logic [2:0] OP_SOLVE = 3'b011;

  state_t      state_q, state_d;
  logic        clr_cmd_rdy_q, clr_cmd_rdy_d;
  logic        strt_hdng_q, strt_hdng_d;
  logic        strt_mv_q, strt_mv_d;
  logic        strt_slv_q, strt_slv_d;
  logic        send_resp_q, send_resp_d;
  logic [11:0] dsrd_hdng_q, dsrd_hdng_d;
  logic        stp_lft_q, stp_lft_d;
  logic        stp_rght_q, stp_rght_d;
  logic        slv_lft_affn_q, slv_lft_affn_d;
  logic        cmd_md_q, cmd_md_d;
  logic [7:0]  resp_q, resp_d;

  // cmd[12] carries no meaning for any opcode.
  logic unused_cmd_bit;
  assign unused_cmd_bit = cmd[12];

`ifdef CMD_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'hE7;
  logic [23:0] wd_q, wd_d;
  logic        wd_expired;

  // Counter is zero in the first waiting cycle, so expiry lands on the
  // TIMEOUT_CYC-th waiting cycle.
  assign wd_expired = (wd_q == TIMEOUT_CYC - 24'd1);

  always_comb begin
    wd_d = 24'd0;
    if (state_q == WT_HDNG || state_q == WT_MV || state_q == WT_SLV)
      wd_d = wd_q + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= 24'd0;
    else     wd_q <= wd_d;
  end
`endif

  always_comb begin
    state_d        = state_q;
    clr_cmd_rdy_d  = 1'b0;
    strt_hdng_d    = 1'b0;
    strt_mv_d      = 1'b0;
    strt_slv_d     = 1'b0;
    send_resp_d    = 1'b0;
    dsrd_hdng_d    = dsrd_hdng_q;
    stp_lft_d      = stp_lft_q;
    stp_rght_d     = stp_rght_q;
    slv_lft_affn_d = slv_lft_affn_q;
    cmd_md_d       = cmd_md_q;
    resp_d         = resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy_d = 1'b1;
          case (cmd[15:13])
            OP_HDNG: begin
              dsrd_hdng_d = cmd[11:0];
              strt_hdng_d = 1'b1;
              state_d     = WT_HDNG;
            end
            OP_MOVE: begin
              stp_lft_d  = cmd[1];
              stp_rght_d = cmd[0];
              strt_mv_d  = 1'b1;
              state_d    = WT_MV;
            end
            OP_SOLVE: begin
              slv_lft_affn_d = cmd[0];
              strt_slv_d     = 1'b1;
              cmd_md_d       = 1'b0;
              state_d        = WT_SLV;
            end
            default: begin
              resp_d  = NAK;
              state_d = RESP;
            end
          endcase
        end
      end
      WT_HDNG, WT_MV: begin
        // sol_cmplt has no meaning while navigation is under command.
        if (mv_cmplt) begin
          resp_d  = ACK;
          state_d = RESP;
        end
`ifdef CMD_TIMEOUT_EN
        else if (wd_expired) begin
          resp_d   = TMO;
          cmd_md_d = 1'b1;
          state_d  = RESP;
        end
`endif
      end
      WT_SLV: begin
        // The solver drives navigation itself, so its mv_cmplt pulses
        // are intermediate steps, not the end of this command.
        if (sol_cmplt) begin
          cmd_md_d = 1'b1;
          resp_d   = ACK;
          state_d  = RESP;
        end
`ifdef CMD_TIMEOUT_EN
        else if (wd_expired) begin
          resp_d   = TMO;
          cmd_md_d = 1'b1;
          state_d  = RESP;
        end
`endif
      end
      RESP: begin
        send_resp_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      clr_cmd_rdy_q  <= 1'b0;
      strt_hdng_q    <= 1'b0;
      strt_mv_q      <= 1'b0;
      strt_slv_q     <= 1'b0;
      send_resp_q    <= 1'b0;
      dsrd_hdng_q    <= 12'h000;
      stp_lft_q      <= 1'b0;
      stp_rght_q     <= 1'b0;
      slv_lft_affn_q <= 1'b0;
      cmd_md_q       <= 1'b1;
      resp_q         <= 8'h00;
    end else begin
      state_q        <= state_d;
      clr_cmd_rdy_q  <= clr_cmd_rdy_d;
      strt_hdng_q    <= strt_hdng_d;
      strt_mv_q      <= strt_mv_d;
      strt_slv_q     <= strt_slv_d;
      send_resp_q    <= send_resp_d;
      dsrd_hdng_q    <= dsrd_hdng_d;
      stp_lft_q      <= stp_lft_d;
      stp_rght_q     <= stp_rght_d;
      slv_lft_affn_q <= slv_lft_affn_d;
      cmd_md_q       <= cmd_md_d;
      resp_q         <= resp_d;
    end
  end

  assign clr_cmd_rdy  = clr_cmd_rdy_q;
  assign strt_hdng    = strt_hdng_q;
  assign strt_mv      = strt_mv_q;
  assign strt_slv     = strt_slv_q;
  assign send_resp    = send_resp_q;
  assign dsrd_hdng    = dsrd_hdng_q;
  assign stp_lft      = stp_lft_q;
  assign stp_rght     = stp_rght_q;
  assign slv_lft_affn = slv_lft_affn_q;
  assign cmd_md       = cmd_md_q;
  assign resp         = resp_q;

endmodule
